right_shift_stream: RTL and testbench

//  Streaming valid/ready wrapper that feeds the generic right shifter (RightShiftGen) and buffers its result.

---
 rtl/right_shift_stream_pkg.sv | 26 ++
 rtl/right_shift_stream_if.sv | 24 ++
 rtl/right_shift_stream_gen.sv | 21 ++
 rtl/right_shift_stream.sv | 82 ++++++++
 tb/tb_right_shift_stream.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/right_shift_stream_pkg.sv
// Shared types and constants for the right-shift streaming wrapper.
package right_shift_stream_pkg;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return (r < 1) ? 1 : r;
   endfunction

   localparam int DATA_W    = 8;
   localparam int SHIFT_W   = clog2(DATA_W);
   localparam int BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } cnt_e;

   typedef struct packed {
      logic [DATA_W-1:0] bits;
      logic              lost;
   } res_t;

endpackage

// File: rtl/right_shift_stream_if.sv
// Operand-in / result-out handshake bundle; master is the producer+consumer side.
interface right_shift_stream_if;
   import right_shift_stream_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_bits;
   logic [SHIFT_W-1:0] in_shift;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_bits;
   logic               out_lost;

   modport master (
      output in_valid, in_bits, in_shift, out_ready,
      input  in_ready, out_valid, out_bits, out_lost
   );

   modport slave (
      input  in_valid, in_bits, in_shift, out_ready,
      output in_ready, out_valid, out_bits, out_lost
   );

endinterface

// File: rtl/right_shift_stream_gen.sv
// Purpose: generic logical right shifter, zero fill from the MSB side.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module right_shift_gen #(
   parameter int width   = 8,
   parameter int shift_w = 3
) (
   input  logic [width-1:0]   bits,
   input  logic [shift_w-1:0] shift,
   output logic [width-1:0]   shifted
);

   // Shift codes past the data width exist only for non-power-of-2 widths.
   always_comb begin
      shifted = '0;
      if (int'(shift) < width) begin
         shifted = bits >> shift;
      end
   end

endmodule

// File: rtl/right_shift_stream.sv
// Purpose: valid/ready wrapper around right_shift_gen with a sticky lost-bit flag.
// Latency: 1 clk from accept to out_valid when the buffer is empty; 1 word/clk.
// Backpressure: 2-entry result buffer; in_ready depends only on registered count.
module right_shift_stream
   import right_shift_stream_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   right_shift_stream_if.slave   io
);

   cnt_e              count_q, count_d;
   logic              head_q, head_d;
   logic              tail_q, tail_d;
   res_t              buf_q [BUF_DEPTH];
   res_t              buf_d [BUF_DEPTH];
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lost_mask;
   res_t              new_res;
   logic              accept;
   logic              pop;

   right_shift_gen #(
      .width   (DATA_W),
      .shift_w (SHIFT_W)
   ) u_shift (
      .bits    (io.in_bits),
      .shift   (io.in_shift),
      .shifted (shifted)
   );

   // Ones below the shift point; saturates to all-ones when shift >= width.
   assign lost_mask    = ~({DATA_W{1'b1}} << io.in_shift);
   assign new_res.bits = shifted;
   assign new_res.lost = |(io.in_bits & lost_mask);

   assign io.in_ready  = (count_q != TWO);
   assign io.out_valid = (count_q != EMPTY);
   assign io.out_bits  = io.out_valid ? buf_q[head_q].bits : '0;
   assign io.out_lost  = io.out_valid ? buf_q[head_q].lost : 1'b0;

   assign accept = io.in_valid & io.in_ready;
   assign pop    = io.out_valid & io.out_ready;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      buf_d   = buf_q;
      if (accept) begin
         buf_d[tail_q] = new_res;
         tail_d        = ~tail_q;
      end
      if (pop) begin
         head_d = ~head_q;
      end
      case (count_q)
         EMPTY: if (accept) count_d = ONE;
         ONE: begin
            if (accept && !pop)      count_d = TWO;
            else if (pop && !accept) count_d = EMPTY;
         end
         TWO:     if (pop) count_d = ONE;
         default: count_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= EMPTY;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         buf_q   <= '{default: '0};
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         buf_q   <= buf_d;
      end
   end

endmodule

// File: tb/tb_right_shift_stream.sv
// Directed + random bench for right_shift_stream against a queue-based reference.
module tb_right_shift_stream;
   import right_shift_stream_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [8:0] model_q [$];

   right_shift_stream_if ifc ();

   right_shift_stream dut (
      .clk (clk),
      .rst (rst),
      .io  (ifc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref_result(input int b, input int s);
      int r;
      int l;
      r = (s >= DATA_W) ? 0 : (b / (1 << s));
      l = ((b % (1 << s)) != 0) ? 1 : 0;
      return {r[7:0], l[0]};
   endfunction

   // Called at a negedge: drive, check pre-edge outputs, advance through one posedge.
   task automatic cycle(input logic iv, input logic [7:0] ib, input logic [2:0] is,
                        input logic ordy, output logic acc);
      logic       pop;
      logic [8:0] head;
      ifc.in_valid  = iv;
      ifc.in_bits   = ib;
      ifc.in_shift  = is;
      ifc.out_ready = ordy;
      chk("in_ready", ifc.in_ready, (model_q.size() < 2) ? 1 : 0);
      chk("out_valid", ifc.out_valid, (model_q.size() > 0) ? 1 : 0);
      head = (model_q.size() > 0) ? model_q[0] : 9'd0;
      chk("out_bits", ifc.out_bits, head[8:1]);
      chk("out_lost", ifc.out_lost, head[0]);
      acc = iv && (model_q.size() < 2) && !rst;
      pop = (model_q.size() > 0) && ordy && !rst;
      @(posedge clk);
      if (rst) begin
         model_q.delete();
      end else begin
         if (pop) void'(model_q.pop_front());
         if (acc) model_q.push_back(ref_result(int'(ib), int'(is)));
      end
      @(negedge clk);
   endtask

   initial begin
      logic       acc;
      logic [7:0] first_bits;
      logic [7:0] rb;
      logic [2:0] rs;
      int         tries;

      // 1: reset held 3 clocks with a word offered
      ifc.in_valid  = 1'b1;
      ifc.in_bits   = 8'hA5;
      ifc.in_shift  = 3'd1;
      ifc.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cycle(1'b1, 8'hA5, 3'd1, 1'b0, acc);
      cycle(1'b1, 8'h5A, 3'd2, 1'b0, acc);
      rst = 1'b0;
      cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
      chk("rst_nothing_captured", ifc.out_valid, 0);

      // 2: single words
      cycle(1'b1, 8'hB4, 3'd2, 1'b1, acc);
      chk("t2a_bits", ifc.out_bits, 8'h2D);
      chk("t2a_lost", ifc.out_lost, 0);
      cycle(1'b1, 8'hB5, 3'd3, 1'b1, acc);
      chk("t2b_bits", ifc.out_bits, 8'h16);
      chk("t2b_lost", ifc.out_lost, 1);
      cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);

      // 3: back-pressure with three words offered
      cycle(1'b1, 8'hF0, 3'd4, 1'b0, acc);
      first_bits = ifc.out_bits;
      chk("t3_first", first_bits, 8'h0F);
      cycle(1'b1, 8'h3C, 3'd1, 1'b0, acc);
      chk("t3_full_ready", ifc.in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 8'h77, 3'd5, 1'b0, acc);
         chk("t3_no_accept_full", acc, 0);
         chk("t3_hold", ifc.out_bits, first_bits);
      end
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 10) begin
         cycle(1'b1, 8'h77, 3'd5, 1'b1, acc);
         tries++;
      end
      chk("t3_third_accepted", acc, 1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);

      // 4: full throughput random stream
      for (int i = 0; i < 100; i++) begin
         rb = 8'($urandom);
         rs = 3'($urandom_range(0, 7));
         cycle(1'b1, rb, rs, 1'b1, acc);
         chk("t4_accept", acc, 1);
         chk("t4_latency", ifc.out_valid, 1);
      end
      cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);

      // 4b: random valid/ready mix
      for (int i = 0; i < 200; i++) begin
         cycle(1'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), acc);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);

      // 5: boundaries
      cycle(1'b1, 8'hFF, 3'd0, 1'b1, acc);
      chk("t5a_bits", ifc.out_bits, 8'hFF);
      chk("t5a_lost", ifc.out_lost, 0);
      cycle(1'b1, 8'h80, 3'd7, 1'b1, acc);
      chk("t5b_bits", ifc.out_bits, 8'h01);
      chk("t5b_lost", ifc.out_lost, 0);
      cycle(1'b1, 8'h81, 3'd7, 1'b1, acc);
      chk("t5c_bits", ifc.out_bits, 8'h01);
      chk("t5c_lost", ifc.out_lost, 1);
      cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);

      // 6: reset while full
      cycle(1'b1, 8'h12, 3'd1, 1'b0, acc);
      cycle(1'b1, 8'h34, 3'd2, 1'b0, acc);
      chk("t6_full", ifc.in_ready, 0);
      rst = 1'b1;
      cycle(1'b1, 8'h56, 3'd3, 1'b1, acc);
      rst = 1'b0;
      chk("t6_rst_valid", ifc.out_valid, 0);
      chk("t6_rst_ready", ifc.in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
         chk("t6_no_stale", ifc.out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
